counter_updown_mod: RTL and testbench

//  Parametrised up/down modulo-N binary counter; next generation of our async-reset counter.

---
 rtl/counter_updown_mod.sv | 109 ++++++++++
 tb/tb_counter_updown_mod.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// Up/down modulo-MODULUS counter with sync clear/load, wrap/saturate, tc pulse and sticky ovf.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN (PRESCALE enabled cycles per step).
module counter_updown_mod #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 2 ** WIDTH,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up_down,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step_due_c;
    logic [WIDTH-1:0] load_clamped_c;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // A step is due only on the enabled cycle that closes a prescale period.
    assign step_due_c = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (clear || load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = step_due_c ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE == 0);
    assign step_due_c      = 1'b1;
`endif

    assign load_clamped_c = (32'(load_value) >= MODULUS) ? MAX_VAL : load_value;

    // Next-state: clear > load > enabled step; tc is a single-cycle pulse.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped_c;
        end else if (en && step_due_c) begin
            if (up_down) begin
                if (count_q == MAX_VAL) begin
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = sat_mode ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = sat_mode ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out = count_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed plus randomized bench for counter_updown_mod (WIDTH=4, MODULUS=10, PRESCALE=4).
module tb_counter_updown_mod;

    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int PRE = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         en = 1'b0;
    logic         up_down = 1'b1;
    logic         sat_mode = 1'b0;
    logic [W-1:0] out;
    logic         tc;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_out = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_pre = 0;

    counter_updown_mod #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(PRE)) dut (
        .clock(clock), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .en(en), .up_down(up_down), .sat_mode(sat_mode),
        .out(out), .tc(tc), .ovf(ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, int'(out), m_out);
        check({tag, ".tc"},  int'(tc),  m_tc);
        check({tag, ".ovf"}, int'(ovf), m_ovf);
    endtask

    function automatic void model_edge();
        bit due;
        bit boundary;
        m_tc = 0;
        if (clear) begin
            m_out = 0; m_ovf = 0; m_pre = 0;
        end else if (load) begin
            m_out = (int'(load_value) >= MOD) ? MOD - 1 : int'(load_value);
            m_pre = 0;
        end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
            due   = (m_pre == PRE - 1);
            m_pre = due ? 0 : m_pre + 1;
`else
            due = 1'b1;
`endif
            if (due) begin
                boundary = up_down ? (m_out == MOD - 1) : (m_out == 0);
                if (!boundary)
                    m_out = up_down ? m_out + 1 : m_out - 1;
                else if (!sat_mode)
                    m_out = (m_out + (up_down ? 1 : MOD - 1)) % MOD;
                if (boundary) begin
                    m_tc = 1; m_ovf = 1;
                end
            end
        end
    endfunction

    task automatic step(input string tag, input bit c, input bit l, input int lv,
                        input bit e, input bit ud, input bit sm);
        clear = c; load = l; load_value = W'(lv); en = e; up_down = ud; sat_mode = sm;
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held from time 0
        #12;
        check_all("reset_init");
        reset = 1'b1;

        // Async reset mid-cycle from out=7
        step("load7", 0, 1, 7, 0, 1, 0);
        #3 reset = 1'b0;
        #1;
        m_out = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
        check_all("async_reset");
        reset = 1'b1;

        // Up wrap 0..9,0
        step("clr", 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step("up_wrap", 0, 0, 0, 1, 1, 0);

        // Down saturate from 2
        step("load2", 0, 1, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("dn_sat", 0, 0, 0, 1, 0, 1);

        // Priority and clamp
        step("clr_ld_en", 1, 1, 5, 1, 1, 0);
        step("ld_clamp", 0, 1, 12, 1, 1, 0);
        step("ld_bound_en", 0, 1, 9, 1, 1, 0);

        // Down wrap from 0, then tc must drop
        step("load0", 0, 1, 0, 0, 0, 0);
        step("dn_wrap", 0, 0, 0, 1, 0, 0);
        step("hold", 0, 0, 0, 0, 0, 0);
        step("hold2", 0, 0, 0, 0, 1, 1);

        // Up saturate repeated attempts
        step("load9", 0, 1, 9, 0, 1, 1);
        for (int i = 0; i < 3; i++) step("up_sat", 0, 0, 0, 1, 1, 1);

        // Prescale-style run with an en gap
        step("clr2", 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 14; i++) step("run_gap", 0, 0, 0, (i != 5 && i != 6), 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0) ^ (i[6]),
                 ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
